// File: rtl/bp_be_pkg.sv
// Back-end package slice used by the late writeback arbiter.
// Provides:
//   bp_params_e / width helpers : processor configuration and derived widths
//   bp_be_wb_pkt_s              : register-file writeback packet
//   bp_be_late_src_e            : which late source owns a grant
//   late_age_max_gp             : age at which a waiting long result wins
package bp_be_pkg;

    typedef enum logic [0:0] {
        e_bp_default_cfg = 1'b0
    } bp_params_e;

    localparam int unsigned bp_reg_addr_width_gp = 5;
    localparam int unsigned bp_dpath_width_gp    = 66;
    localparam int unsigned bp_fflags_width_gp   = 5;

    function automatic int unsigned bp_reg_addr_width(input bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return bp_reg_addr_width_gp;
            default:          return bp_reg_addr_width_gp;
        endcase
    endfunction

    function automatic int unsigned bp_dpath_width(input bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return bp_dpath_width_gp;
            default:          return bp_dpath_width_gp;
        endcase
    endfunction

    typedef struct packed {
        logic                                ird_w_v;
        logic                                frd_w_v;
        logic                                late;
        logic                                fflags_w_v;
        logic [bp_reg_addr_width_gp-1:0]     rd_addr;
        logic [bp_dpath_width_gp-1:0]        rd_data;
        logic [bp_fflags_width_gp-1:0]       fflags;
    } bp_be_wb_pkt_s;

    typedef enum logic [0:0] {
        e_late_src_mem  = 1'b0,
        e_late_src_long = 1'b1
    } bp_be_late_src_e;

    localparam logic [1:0] late_age_max_gp = 2'd3;

endpackage

// File: rtl/bp_be_late_wb_arbiter_if.sv
// Bundle of the late writeback arbiter's source, busy and packet signals.
// Signal names are seen from the arbiter (_i = into arbiter, _o = out of it).
//   slave  : the arbiter side
//   master : the sources / pipeline / register-file side
interface bp_be_late_wb_arbiter_if;
    import bp_be_pkg::*;

    logic                                mem_v_i;
    logic                                mem_ready_and_o;
    logic                                mem_fp_i;
    logic [bp_reg_addr_width_gp-1:0]     mem_rd_i;
    logic [bp_dpath_width_gp-1:0]        mem_data_i;

    logic                                long_v_i;
    logic                                long_ready_and_o;
    logic                                long_fp_i;
    logic [bp_reg_addr_width_gp-1:0]     long_rd_i;
    logic [bp_dpath_width_gp-1:0]        long_data_i;
    logic [bp_fflags_width_gp-1:0]       long_fflags_i;

    logic                                iwb_busy_i;
    logic                                fwb_busy_i;

    bp_be_wb_pkt_s                       iwb_pkt_o;
    bp_be_wb_pkt_s                       fwb_pkt_o;
    logic                                empty_o;

    modport slave (
        input  mem_v_i, mem_fp_i, mem_rd_i, mem_data_i,
        input  long_v_i, long_fp_i, long_rd_i, long_data_i, long_fflags_i,
        input  iwb_busy_i, fwb_busy_i,
        output mem_ready_and_o, long_ready_and_o,
        output iwb_pkt_o, fwb_pkt_o, empty_o
    );

    modport master (
        output mem_v_i, mem_fp_i, mem_rd_i, mem_data_i,
        output long_v_i, long_fp_i, long_rd_i, long_data_i, long_fflags_i,
        output iwb_busy_i, fwb_busy_i,
        input  mem_ready_and_o, long_ready_and_o,
        input  iwb_pkt_o, fwb_pkt_o, empty_o
    );

endinterface

// File: rtl/bp_be_late_wb_slot.sv
// One-entry holding slot for a late result source.
//   clk_i, reset_i      : clock, async active-high reset
//   v_i / ready_and_o   : source handshake; ready while empty or being granted
//   fp_i, rd_i, data_i, fflags_i : result captured on transfer
//   grant_i             : held result is issued this cycle
//   full_o, fp_o, rd_o, data_o, fflags_o : held result
//   age_o               : cycles held without a grant (saturating), if enabled
module bp_be_late_wb_slot
    import bp_be_pkg::*;
#(
    parameter int unsigned rd_width_p   = 5,
    parameter int unsigned data_width_p = 66,
    parameter bit          age_en_p     = 1'b0
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      v_i,
    output logic                      ready_and_o,
    input  logic                      fp_i,
    input  logic [rd_width_p-1:0]     rd_i,
    input  logic [data_width_p-1:0]   data_i,
    input  logic [4:0]                fflags_i,
    input  logic                      grant_i,
    output logic                      full_o,
    output logic                      fp_o,
    output logic [rd_width_p-1:0]     rd_o,
    output logic [data_width_p-1:0]   data_o,
    output logic [4:0]                fflags_o,
    output logic [1:0]                age_o
);

    logic                    full_q, full_d;
    logic                    fp_q, fp_d;
    logic [rd_width_p-1:0]   rd_q, rd_d;
    logic [data_width_p-1:0] data_q, data_d;
    logic [4:0]              fflags_q, fflags_d;
    logic [1:0]              age_q, age_d;
    logic                    ready;

    // A granted slot accepts a new result in the same cycle it drains.
    assign ready = ~full_q | grant_i;

    always_comb begin
        full_d   = full_q;
        fp_d     = fp_q;
        rd_d     = rd_q;
        data_d   = data_q;
        fflags_d = fflags_q;
        age_d    = '0;
        if (v_i && ready) begin
            full_d   = 1'b1;
            fp_d     = fp_i;
            rd_d     = rd_i;
            data_d   = data_i;
            fflags_d = fflags_i;
        end else if (grant_i) begin
            full_d   = 1'b0;
        end
        if (age_en_p && full_q && !grant_i) begin
            age_d = (age_q == late_age_max_gp) ? age_q : age_q + 2'd1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            full_q   <= 1'b0;
            fp_q     <= 1'b0;
            rd_q     <= '0;
            data_q   <= '0;
            fflags_q <= '0;
            age_q    <= '0;
        end else begin
            full_q   <= full_d;
            fp_q     <= fp_d;
            rd_q     <= rd_d;
            data_q   <= data_d;
            fflags_q <= fflags_d;
            age_q    <= age_d;
        end
    end

    assign ready_and_o = ready;
    assign full_o      = full_q;
    assign fp_o        = fp_q;
    assign rd_o        = rd_q;
    assign data_o      = data_q;
    assign fflags_o    = fflags_q;
    assign age_o       = age_q;

endmodule

// File: rtl/bp_be_late_wb_arbiter.sv
// Late writeback arbiter: buffers one miss-fill (mem) and one long-latency
// (div/fdiv/fsqrt) result and issues them into idle register-file write
// ports. Integer and FP files are arbitrated independently.
//   clk_i, reset_i : clock, async active-high reset
//   io (slave)     : source handshakes, write-port busy flags,
//                    late integer / FP writeback packets, empty flag
module bp_be_late_wb_arbiter
    import bp_be_pkg::*;
#(
    parameter bp_params_e bp_params_p = e_bp_default_cfg
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    bp_be_late_wb_arbiter_if.slave    io
);

    localparam int unsigned reg_addr_width_gp = bp_reg_addr_width(bp_params_p);
    localparam int unsigned dpath_width_gp    = bp_dpath_width(bp_params_p);

    logic                         mem_full, mem_fp, mem_grant;
    logic [reg_addr_width_gp-1:0] mem_rd;
    logic [dpath_width_gp-1:0]    mem_data;

    logic                         long_full, long_fp, long_grant;
    logic [reg_addr_width_gp-1:0] long_rd;
    logic [dpath_width_gp-1:0]    long_data;
    logic [4:0]                   long_fflags;
    logic [1:0]                   long_age;

    bp_be_late_wb_slot #(
        .rd_width_p   (reg_addr_width_gp),
        .data_width_p (dpath_width_gp),
        .age_en_p     (1'b0)
    ) mem_slot (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .v_i         (io.mem_v_i),
        .ready_and_o (io.mem_ready_and_o),
        .fp_i        (io.mem_fp_i),
        .rd_i        (io.mem_rd_i),
        .data_i      (io.mem_data_i),
        .fflags_i    (5'b0),
        .grant_i     (mem_grant),
        .full_o      (mem_full),
        .fp_o        (mem_fp),
        .rd_o        (mem_rd),
        .data_o      (mem_data),
        .fflags_o    (),
        .age_o       ()
    );

    bp_be_late_wb_slot #(
        .rd_width_p   (reg_addr_width_gp),
        .data_width_p (dpath_width_gp),
        .age_en_p     (1'b1)
    ) long_slot (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .v_i         (io.long_v_i),
        .ready_and_o (io.long_ready_and_o),
        .fp_i        (io.long_fp_i),
        .rd_i        (io.long_rd_i),
        .data_i      (io.long_data_i),
        .fflags_i    (io.long_fflags_i),
        .grant_i     (long_grant),
        .full_o      (long_full),
        .fp_o        (long_fp),
        .rd_o        (long_rd),
        .data_o      (long_data),
        .fflags_o    (long_fflags),
        .age_o       (long_age)
    );

    logic            mem_int_c, mem_fp_c, long_int_c, long_fp_c, age_sat;
    logic            iwb_v, fwb_v;
    bp_be_late_src_e iwb_src, fwb_src;

    // mem has priority on contention; a long result that has waited
    // late_age_max_gp cycles takes the port instead so it cannot starve.
    always_comb begin
        mem_int_c  = mem_full  & ~mem_fp;
        mem_fp_c   = mem_full  &  mem_fp;
        long_int_c = long_full & ~long_fp;
        long_fp_c  = long_full &  long_fp;
        age_sat    = (long_age == late_age_max_gp);

        iwb_v   = ~io.iwb_busy_i & (mem_int_c | long_int_c);
        fwb_v   = ~io.fwb_busy_i & (mem_fp_c  | long_fp_c);
        iwb_src = (long_int_c && (!mem_int_c || age_sat)) ? e_late_src_long : e_late_src_mem;
        fwb_src = (long_fp_c  && (!mem_fp_c  || age_sat)) ? e_late_src_long : e_late_src_mem;

        mem_grant  = (iwb_v && iwb_src == e_late_src_mem)  || (fwb_v && fwb_src == e_late_src_mem);
        long_grant = (iwb_v && iwb_src == e_late_src_long) || (fwb_v && fwb_src == e_late_src_long);
    end

    bp_be_wb_pkt_s iwb_pkt, fwb_pkt;

    always_comb begin
        iwb_pkt = '0;
        fwb_pkt = '0;
        if (iwb_v) begin
            iwb_pkt.ird_w_v = 1'b1;
            iwb_pkt.late    = 1'b1;
            iwb_pkt.rd_addr = (iwb_src == e_late_src_long) ? long_rd   : mem_rd;
            iwb_pkt.rd_data = (iwb_src == e_late_src_long) ? long_data : mem_data;
        end
        if (fwb_v) begin
            fwb_pkt.frd_w_v = 1'b1;
            fwb_pkt.late    = 1'b1;
            fwb_pkt.rd_addr = (fwb_src == e_late_src_long) ? long_rd   : mem_rd;
            fwb_pkt.rd_data = (fwb_src == e_late_src_long) ? long_data : mem_data;
            if (fwb_src == e_late_src_long) begin
                fwb_pkt.fflags_w_v = 1'b1;
                fwb_pkt.fflags     = long_fflags;
            end
        end
    end

    assign io.iwb_pkt_o = iwb_pkt;
    assign io.fwb_pkt_o = fwb_pkt;
    assign io.empty_o   = ~mem_full & ~long_full;

endmodule

// File: tb/tb_bp_be_late_wb_arbiter.sv
module tb_bp_be_late_wb_arbiter;
    import bp_be_pkg::*;

    logic clk;
    logic reset;

    bp_be_late_wb_arbiter_if ifc ();

    bp_be_late_wb_arbiter #(.bp_params_p(e_bp_default_cfg)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .io      (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int accepted = 0;
    int issued   = 0;

    // Reference model: what each source currently holds, index 0 = mem, 1 = long.
    bit          m_held [2];
    bit          m_fp   [2];
    logic [4:0]  m_rd   [2];
    logic [65:0] m_data [2];
    logic [4:0]  m_ff   [2];
    int          m_age;
    bit          e_gnt  [2];

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        total++;
        assert (act === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < 2; s++) begin
            if (m_held[s]) accepted--;
            m_held[s] = 1'b0;
            e_gnt[s]  = 1'b0;
        end
        m_age = 0;
    endtask

    task automatic drive(input bit mv, input bit mfp, input logic [4:0] mrd, input logic [65:0] md,
                         input bit lv, input bit lfp, input logic [4:0] lrd, input logic [65:0] ld,
                         input logic [4:0] lff, input bit ib, input bit fb);
        ifc.mem_v_i       = mv;
        ifc.mem_fp_i      = mfp;
        ifc.mem_rd_i      = mrd;
        ifc.mem_data_i    = md;
        ifc.long_v_i      = lv;
        ifc.long_fp_i     = lfp;
        ifc.long_rd_i     = lrd;
        ifc.long_data_i   = ld;
        ifc.long_fflags_i = lff;
        ifc.iwb_busy_i    = ib;
        ifc.fwb_busy_i    = fb;
    endtask

    task automatic idle();
        drive(0, 0, 5'd0, 66'd0, 0, 0, 5'd0, 66'd0, 5'd0, 0, 0);
    endtask

    // Decide the winners from the held results and compare every output.
    task automatic check_model();
        bp_be_wb_pkt_s ep [2];
        bit gnt [2];
        gnt[0] = 1'b0;
        gnt[1] = 1'b0;
        for (int f = 0; f < 2; f++) begin
            int w;
            bit busy;
            bit mc;
            bit lc;
            w    = -1;
            busy = (f == 0) ? ifc.iwb_busy_i : ifc.fwb_busy_i;
            mc   = m_held[0] && (m_fp[0] == (f == 1));
            lc   = m_held[1] && (m_fp[1] == (f == 1));
            if (!busy) begin
                if (mc && lc)  w = (m_age >= 3) ? 1 : 0;
                else if (mc)   w = 0;
                else if (lc)   w = 1;
            end
            ep[f] = '0;
            if (w >= 0) begin
                gnt[w] = 1'b1;
                ep[f].late = 1'b1;
                if (f == 0) ep[f].ird_w_v = 1'b1;
                else        ep[f].frd_w_v = 1'b1;
                ep[f].rd_addr = m_rd[w];
                ep[f].rd_data = m_data[w];
                if (f == 1 && w == 1) begin
                    ep[f].fflags_w_v = 1'b1;
                    ep[f].fflags     = m_ff[w];
                end
            end
        end
        chk("iwb_pkt",    128'(ifc.iwb_pkt_o),        128'(ep[0]));
        chk("fwb_pkt",    128'(ifc.fwb_pkt_o),        128'(ep[1]));
        chk("mem_ready",  128'(ifc.mem_ready_and_o),  128'(!m_held[0] || gnt[0]));
        chk("long_ready", 128'(ifc.long_ready_and_o), 128'(!m_held[1] || gnt[1]));
        chk("empty",      128'(ifc.empty_o),          128'(!m_held[0] && !m_held[1]));
        e_gnt[0] = gnt[0];
        e_gnt[1] = gnt[1];
    endtask

    task automatic model_next();
        bit xfer [2];
        xfer[0] = ifc.mem_v_i  && (!m_held[0] || e_gnt[0]);
        xfer[1] = ifc.long_v_i && (!m_held[1] || e_gnt[1]);
        if (m_held[1] && !e_gnt[1]) m_age = (m_age < 3) ? m_age + 1 : 3;
        else                        m_age = 0;
        for (int s = 0; s < 2; s++) begin
            if (e_gnt[s]) issued++;
            if (xfer[s]) begin
                accepted++;
                m_held[s] = 1'b1;
                m_fp[s]   = (s == 0) ? ifc.mem_fp_i   : ifc.long_fp_i;
                m_rd[s]   = (s == 0) ? ifc.mem_rd_i   : ifc.long_rd_i;
                m_data[s] = (s == 0) ? ifc.mem_data_i : ifc.long_data_i;
                m_ff[s]   = (s == 0) ? 5'd0           : ifc.long_fflags_i;
            end else if (e_gnt[s]) begin
                m_held[s] = 1'b0;
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
        check_model();
    endtask

    task automatic advance();
        model_next();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        settle();
        advance();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int arb_exp [8];
        logic [95:0] r0;
        logic [95:0] r1;
        arb_exp = '{1, 1, 1, 2, 1, 1, 1, 2};

        reset = 1'b1;
        idle();
        m_held[0] = 1'b0;
        m_held[1] = 1'b0;
        m_age = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_iwb",   128'(ifc.iwb_pkt_o),        128'd0);
        chk("rst_fwb",   128'(ifc.fwb_pkt_o),        128'd0);
        chk("rst_empty", 128'(ifc.empty_o),          128'd1);
        chk("rst_mrdy",  128'(ifc.mem_ready_and_o),  128'd1);
        chk("rst_lrdy",  128'(ifc.long_ready_and_o), 128'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // single mem integer result
        drive(1, 0, 5'd5, 66'hAB, 0, 0, 5'd0, 66'd0, 5'd0, 0, 0);
        cyc();
        idle();
        settle();
        chk("single_v",    128'(ifc.iwb_pkt_o.ird_w_v), 128'd1);
        chk("single_late", 128'(ifc.iwb_pkt_o.late),    128'd1);
        chk("single_rd",   128'(ifc.iwb_pkt_o.rd_addr), 128'd5);
        chk("single_data", 128'(ifc.iwb_pkt_o.rd_data), 128'hAB);
        advance();
        settle();
        chk("single_empty", 128'(ifc.empty_o), 128'd1);
        advance();

        // int from mem and FP from long together
        drive(1, 0, 5'd3, 66'h33, 1, 1, 5'd7, 66'h77, 5'h01, 0, 0);
        cyc();
        idle();
        settle();
        chk("dual_ird",   128'(ifc.iwb_pkt_o.ird_w_v),    128'd1);
        chk("dual_irdad", 128'(ifc.iwb_pkt_o.rd_addr),    128'd3);
        chk("dual_frd",   128'(ifc.fwb_pkt_o.frd_w_v),    128'd1);
        chk("dual_frdad", 128'(ifc.fwb_pkt_o.rd_addr),    128'd7);
        chk("dual_ffv",   128'(ifc.fwb_pkt_o.fflags_w_v), 128'd1);
        chk("dual_ff",    128'(ifc.fwb_pkt_o.fflags),     128'h01);
        advance();
        repeat (2) cyc();

        // both sources streaming integer results: long wins every 4th cycle
        for (int i = 0; i < 9; i++) begin
            drive(1, 0, 5'd1, 66'(i), 1, 0, 5'd2, 66'(i + 100), 5'd0, 0, 0);
            settle();
            if (i > 0) chk("age_arb_rd", 128'(ifc.iwb_pkt_o.rd_addr), 128'(arb_exp[i-1]));
            advance();
        end
        idle();
        repeat (3) cyc();

        // integer port busy with both slots full
        drive(1, 0, 5'd9, 66'h99, 1, 0, 5'd10, 66'h1010, 5'd0, 1, 0);
        cyc();
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 5'd11, 66'h11, 1, 0, 5'd12, 66'h12, 5'd0, 1, 0);
            settle();
            chk("busy_mrdy", 128'(ifc.mem_ready_and_o),   128'd0);
            chk("busy_lrdy", 128'(ifc.long_ready_and_o),  128'd0);
            chk("busy_iwb",  128'(ifc.iwb_pkt_o.ird_w_v), 128'd0);
            advance();
        end
        idle();
        repeat (3) cyc();

        // back-to-back mem transfers drain at one per cycle
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, 5'(i + 1), 66'(i * 7), 0, 0, 5'd0, 66'd0, 5'd0, 0, 0);
            settle();
            chk("b2b_rdy", 128'(ifc.mem_ready_and_o), 128'd1);
            if (i > 0) chk("b2b_rd", 128'(ifc.iwb_pkt_o.rd_addr), 128'(i));
            advance();
        end
        idle();
        repeat (2) cyc();

        // reset with both slots full
        drive(1, 0, 5'd13, 66'h13, 1, 1, 5'd14, 66'h14, 5'h3, 1, 1);
        cyc();
        idle();
        #2;
        chk("prerst_iwb", 128'(ifc.iwb_pkt_o.ird_w_v), 128'd1);
        chk("prerst_fwb", 128'(ifc.fwb_pkt_o.frd_w_v), 128'd1);
        reset = 1'b1;
        #1;
        chk("midrst_iwb",   128'(ifc.iwb_pkt_o),        128'd0);
        chk("midrst_fwb",   128'(ifc.fwb_pkt_o),        128'd0);
        chk("midrst_empty", 128'(ifc.empty_o),          128'd1);
        chk("midrst_mrdy",  128'(ifc.mem_ready_and_o),  128'd1);
        chk("midrst_lrdy",  128'(ifc.long_ready_and_o), 128'd1);
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) cyc();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            r0 = {$urandom, $urandom, $urandom};
            r1 = {$urandom, $urandom, $urandom};
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom), r0[65:0],
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom), r1[65:0],
                  5'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
            cyc();
        end
        idle();
        repeat (4) cyc();

        chk("no_loss",     128'(issued),      128'(accepted));
        chk("final_empty", 128'(ifc.empty_o), 128'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
